// File: rtl/bridge_axi_pkg.sv
// Shared definitions for the sram-to-AXI bridge (read and write channels).
// Holds the AXI burst/response constants, the sram size encodings and the
// channel FSM state enum.
package bridge_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    WAIT_B = 2'd2,
    RESP   = 2'd3
  } ch_state_e;

endpackage

// File: rtl/aw_w_b_channel.sv
// Write half of the sram-to-AXI bridge. Accepts one sram-like write request
// at a time and issues a single-beat AXI write (AW + W), then waits for B
// before reporting completion.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   data_sram_*            sram-like request side (reads ignored here)
//   wr_addr_ok             request accepted this cycle (combinational)
//   wr_data_ok             write completed, one-cycle pulse
//   aw*/w*/b*              AXI write address/data/response channels
//   wr_busy                a write is accepted but not yet completed
//   wr_pend_addr           word-aligned address of the pending write
//   wr_err                 sticky error on non-OKAY bresp (AXI_BRESP_CHECK_EN only)
//
// Build option: define AXI_BRESP_CHECK_EN to add the wr_err output.
module aw_w_b_channel
  import bridge_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_sram_req,
  input  logic                  data_sram_wr,
  input  logic [1:0]            data_sram_size,
  input  logic [DATA_W/8-1:0]   data_sram_wstrb,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic                  wr_addr_ok,
  output logic                  wr_data_ok,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
`ifdef AXI_BRESP_CHECK_EN
  output logic                  wr_err,
`endif
  output logic                  wr_busy,
  output logic [ADDR_W-1:0]     wr_pend_addr
);

  ch_state_e             state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_W/8-1:0]   strb_q, strb_d;
  logic [1:0]            size_q, size_d;

`ifdef AXI_BRESP_CHECK_EN
  logic                  err_q, err_d;
  logic                  unused_b;
  assign unused_b = ^bid;
  assign wr_err   = err_q;
`else
  // Single outstanding write: B id/resp carry no information we act on.
  logic                  unused_b;
  assign unused_b = ^{bid, bresp};
`endif

  assign wr_addr_ok = (state_q == IDLE) && data_sram_req && data_sram_wr;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    size_d    = size_q;
`ifdef AXI_BRESP_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_addr_ok) begin
          addr_d    = data_sram_addr;
          data_d    = data_sram_wdata;
          strb_d    = data_sram_wstrb;
          size_d    = data_sram_size;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        // Each channel retires on its own handshake; leave once both have.
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = WAIT_B;
      end
      WAIT_B: begin
        if (bvalid) begin
          state_d = RESP;
`ifdef AXI_BRESP_CHECK_EN
          if (bresp != RESP_OKAY) err_d = 1'b1;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      size_q    <= '0;
`ifdef AXI_BRESP_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      size_q    <= size_d;
`ifdef AXI_BRESP_CHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = awvalid_q;

  assign wid     = AXI_ID;
  assign wdata   = data_q;
  assign wstrb   = strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;

  assign bready     = (state_q == WAIT_B);
  assign wr_data_ok = (state_q == RESP);

  assign wr_busy      = (state_q != IDLE);
  assign wr_pend_addr = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_aw_w_b_channel.sv
// Directed bench for aw_w_b_channel. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
// Cycle 0 below is the cycle in which the request is presented and accepted.
module tb_aw_w_b_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        wr_addr_ok, wr_data_ok;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        wr_busy;
  logic [31:0] wr_pend_addr;
`ifdef AXI_BRESP_CHECK_EN
  logic        wr_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aw_w_b_channel dut (
    .clk(clk), .reset(reset),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .wr_addr_ok(wr_addr_ok), .wr_data_ok(wr_data_ok),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
`ifdef AXI_BRESP_CHECK_EN
    .wr_err(wr_err),
`endif
    .wr_busy(wr_busy), .wr_pend_addr(wr_pend_addr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                     input logic [3:0] st, input logic [31:0] d);
    data_sram_req   = 1'b1;
    data_sram_wr    = wr;
    data_sram_addr  = a;
    data_sram_size  = sz;
    data_sram_wstrb = st;
    data_sram_wdata = d;
  endtask

  // Finishes a write already in SEND with all readies high: B is returned
  // in the next cycle with the given response and the done pulse follows.
  task automatic finish_b(input logic [1:0] resp, input string tag);
    cyc(); bvalid = 1'b1; bresp = resp; #1;
    chk({tag, "_bready"}, bready, 1'b1);
    cyc(); bvalid = 1'b0; bresp = 2'b00; #1;
    chk({tag, "_data_ok"}, wr_data_ok, 1'b1);
    cyc(); #1;
    chk({tag, "_idle"}, wr_busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0;
    data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
    awready = 1; wready = 1; bid = 4'd1; bresp = 0; bvalid = 0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_data_ok", wr_data_ok, 1'b0);
    chk("rst_busy", wr_busy, 1'b0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_wstrb", wstrb, 4'h0);
`ifdef AXI_BRESP_CHECK_EN
    chk("rst_wr_err", wr_err, 1'b0);
`endif
    cyc(); reset = 1'b0;

    // 1: word write, all readies high
    cyc(); req(1, 32'h1FC0_0010, 2'd2, 4'hF, 32'hDEAD_BEEF); #1;
    chk("t1_addr_ok", wr_addr_ok, 1'b1);
    chk("t1_busy0", wr_busy, 1'b0);
    cyc(); data_sram_req = 0; #1;
    chk("t1_awvalid", awvalid, 1'b1);
    chk("t1_wvalid", wvalid, 1'b1);
    chk("t1_awaddr", awaddr, 32'h1FC0_0010);
    chk("t1_awsize", awsize, 3'd2);
    chk("t1_wdata", wdata, 32'hDEAD_BEEF);
    chk("t1_wstrb", wstrb, 4'hF);
    chk("t1_wlast", wlast, 1'b1);
    chk("t1_awlen", awlen, 8'd0);
    chk("t1_awburst", awburst, 2'b01);
    chk("t1_ids", {awid, wid}, 8'h11);
    chk("t1_consts", {awlock, awcache, awprot}, 9'd0);
    chk("t1_busy", wr_busy, 1'b1);
    chk("t1_pend", wr_pend_addr, 32'h1FC0_0010);
    chk("t1_bready0", bready, 1'b0);
    cyc(); bvalid = 1; #1;
    chk("t1_c2_valids", {awvalid, wvalid}, 2'b00);
    chk("t1_c2_bready", bready, 1'b1);
    chk("t1_c2_data_ok", wr_data_ok, 1'b0);
    cyc(); bvalid = 0; #1;
    chk("t1_c3_data_ok", wr_data_ok, 1'b1);
    cyc(); #1;
    chk("t1_c4_data_ok", wr_data_ok, 1'b0);
    chk("t1_c4_busy", wr_busy, 1'b0);

    // 2: AW/W skew, awready raised at cycle 4
    awready = 0;
    cyc(); req(1, 32'h8000_0104, 2'd2, 4'hF, 32'h1234_5678); #1;
    chk("t2_addr_ok", wr_addr_ok, 1'b1);
    cyc(); data_sram_req = 0; #1;
    chk("t2_c1_valids", {awvalid, wvalid}, 2'b11);
    for (int i = 2; i <= 3; i++) begin
      cyc(); #1;
      chk("t2_hold_valids", {awvalid, wvalid}, 2'b10);
      chk("t2_hold_awaddr", awaddr, 32'h8000_0104);
      chk("t2_hold_bready", bready, 1'b0);
    end
    cyc(); awready = 1; #1;
    chk("t2_c4_awvalid", awvalid, 1'b1);
    chk("t2_c4_bready", bready, 1'b0);
    cyc(); bvalid = 1; #1;
    chk("t2_c5_awvalid", awvalid, 1'b0);
    chk("t2_c5_bready", bready, 1'b1);
    cyc(); bvalid = 0; #1;
    chk("t2_c6_data_ok", wr_data_ok, 1'b1);
    cyc(); #1;
    chk("t2_idle", wr_busy, 1'b0);

    // 3: B 10 cycles late, second request queued behind
    cyc(); req(1, 32'h0000_1000, 2'd2, 4'hF, 32'h0BAD_F00D); #1;
    chk("t3_addr_ok", wr_addr_ok, 1'b1);
    cyc(); req(1, 32'h0000_2008, 2'd2, 4'h3, 32'hCAFE_F00D); #1;
    chk("t3_send_addr_ok", wr_addr_ok, 1'b0);
    for (int i = 2; i <= 11; i++) begin
      cyc(); #1;
      chk("t3_wait_addr_ok", wr_addr_ok, 1'b0);
      chk("t3_wait_busy", wr_busy, 1'b1);
    end
    chk("t3_pend", wr_pend_addr, 32'h0000_1000);
    cyc(); bvalid = 1; #1;
    chk("t3_c12_addr_ok", wr_addr_ok, 1'b0);
    cyc(); bvalid = 0; #1;
    chk("t3_c13_data_ok", wr_data_ok, 1'b1);
    chk("t3_c13_addr_ok", wr_addr_ok, 1'b0);
    cyc(); #1;
    chk("t3_c14_addr_ok", wr_addr_ok, 1'b1);
    chk("t3_c14_data_ok", wr_data_ok, 1'b0);
    cyc(); data_sram_req = 0; #1;
    chk("t3_2nd_awaddr", awaddr, 32'h0000_2008);
    chk("t3_2nd_wdata", wdata, 32'hCAFE_F00D);
    chk("t3_2nd_wstrb", wstrb, 4'h3);
    finish_b(2'b00, "t3_2nd");

    // 4: byte write at an unaligned address
    cyc(); req(1, 32'h0000_0003, 2'd0, 4'b1000, 32'h1100_0000); #1;
    chk("t4_addr_ok", wr_addr_ok, 1'b1);
    cyc(); data_sram_req = 0; #1;
    chk("t4_awsize", awsize, 3'd0);
    chk("t4_wstrb", wstrb, 4'b1000);
    chk("t4_awaddr", awaddr, 32'h0000_0003);
    chk("t4_pend", wr_pend_addr, 32'h0000_0000);
    finish_b(2'b00, "t4");

    // 5a: read request is ignored
    cyc(); req(0, 32'h0000_4000, 2'd2, 4'hF, 32'h0); #1;
    chk("t5_rd_addr_ok", wr_addr_ok, 1'b0);
    cyc(); data_sram_req = 0; #1;
    chk("t5_rd_awvalid", awvalid, 1'b0);
    chk("t5_rd_busy", wr_busy, 1'b0);

    // 5b: reset asserted mid-SEND
    awready = 0; wready = 0;
    cyc(); req(1, 32'h0000_5000, 2'd2, 4'hF, 32'h5555_5555); #1;
    chk("t5_rst_addr_ok", wr_addr_ok, 1'b1);
    cyc(); data_sram_req = 0; #1;
    chk("t5_rst_valids_pre", {awvalid, wvalid}, 2'b11);
    reset = 1; #1;
    chk("t5_rst_valids", {awvalid, wvalid}, 2'b00);
    chk("t5_rst_busy", wr_busy, 1'b0);
    cyc(); reset = 0; awready = 1; wready = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("t5_rst_no_data_ok", wr_data_ok, 1'b0);
      chk("t5_rst_no_awvalid", awvalid, 1'b0);
    end

`ifdef AXI_BRESP_CHECK_EN
    // 6: SLVERR sets wr_err sticky across a later OKAY write
    cyc(); req(1, 32'h0000_6000, 2'd2, 4'hF, 32'h6); #1;
    cyc(); data_sram_req = 0; #1;
    chk("t6_err_before", wr_err, 1'b0);
    finish_b(2'b10, "t6_slverr");
    chk("t6_err_set", wr_err, 1'b1);
    cyc(); req(1, 32'h0000_6004, 2'd2, 4'hF, 32'h7); #1;
    cyc(); data_sram_req = 0; #1;
    finish_b(2'b00, "t6_okay");
    chk("t6_err_sticky", wr_err, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
